// File: rtl/id_stage.sv
// Decode stage for the MIMA RV64 core: classifies the opcode, extracts fields, builds the
// sign-extended immediate, and presents results from a two-entry skid buffer.
module id_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    localparam logic [4:0] OP_BRANCH = 5'b11000;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    logic   legal_op;
    logic   accept;
    logic   consume;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        dec        = '0;
        legal_op   = 1'b1;
        dec.pc     = in_pc;
        dec.opcode = in_inst[6:2];
        dec.funct3 = in_inst[14:12];
        dec.funct7 = in_inst[31:25];
        dec.rd     = in_inst[11:7];
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        unique case (in_inst[6:2])
            5'b00000, 5'b00001, 5'b00011, 5'b00100,
            5'b00110, 5'b11001, 5'b11100:           dec.imm = imm_i;
            5'b01000, 5'b01001:                     dec.imm = imm_s;
            5'b11000:                               dec.imm = imm_b;
            5'b00101, 5'b01101:                     dec.imm = imm_u;
            5'b11011:                               dec.imm = imm_j;
            5'b01011, 5'b01100, 5'b01110, 5'b10000,
            5'b10001, 5'b10010, 5'b10011, 5'b10100: dec.imm = '0;
            default:                                legal_op = 1'b0;
        endcase
        dec.illegal = (in_inst[1:0] != 2'b11) || !legal_op ||
                      ((in_inst[6:2] == OP_BRANCH) && (in_inst[14:13] == 2'b01));
    end

    assign in_ready  = (state_q != TWO) && !rst;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    head_d  = dec;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && consume) begin
                        head_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (consume) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state; entries are reset too because the data outputs must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc      = head_q.pc;
    assign out_opcode  = head_q.opcode;
    assign out_funct3  = head_q.funct3;
    assign out_funct7  = head_q.funct7;
    assign out_rd      = head_q.rd;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_imm     = head_q.imm;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed decode/handshake scenarios plus randomized
// traffic, all checked against a queue-based reference model that decodes arithmetically.
module tb_id_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] in_pc, out_pc, out_imm;
    logic [31:0]     in_inst;
    logic [4:0]      out_opcode, out_rd, out_rs1, out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_illegal;

    always #5 clk = ~clk;

    id_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic        illegal;
    } bundle_t;

    bundle_t dut_b;
    assign dut_b = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                    out_imm, out_illegal};

    bundle_t q[$];
    int errors = 0;
    int checks = 0;

    int legal_ops[21] = '{0, 1, 3, 4, 5, 6, 8, 9, 11, 12, 13, 14, 16, 17, 18, 19, 20, 24, 25, 27, 28};

    function automatic bundle_t decode_model(input logic [63:0] pc, input logic [31:0] inst);
        bundle_t         b;
        longint unsigned w;
        longint          v;
        int              op, f3;
        bit              legal;
        w  = 64'(inst);
        op = int'((w >> 2) % 32);
        f3 = int'((w >> 12) % 8);
        b.pc      = pc;
        b.opcode  = 5'(op);
        b.funct3  = 3'(f3);
        b.funct7  = 7'(w >> 25);
        b.rd      = 5'(w >> 7);
        b.rs1     = 5'(w >> 15);
        b.rs2     = 5'(w >> 20);
        legal = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
        v = 0;
        if (op inside {0, 1, 3, 4, 6, 25, 28}) begin
            v = longint'((w >> 20) % 4096);
            if (v >= 2048) v -= 4096;
        end else if (op inside {8, 9}) begin
            v = longint'(((w >> 25) % 128) * 32 + (w >> 7) % 32);
            if (v >= 2048) v -= 4096;
        end else if (op == 24) begin
            v = longint'(((w >> 31) % 2) * 4096 + ((w >> 7) % 2) * 2048 +
                         ((w >> 25) % 64) * 32 + ((w >> 8) % 16) * 2);
            if (v >= 4096) v -= 8192;
        end else if (op inside {5, 13}) begin
            v = longint'((w / 4096) * 4096);
            if (v >= 64'sd2147483648) v -= 64'sd4294967296;
        end else if (op == 27) begin
            v = longint'(((w >> 31) % 2) * 1048576 + ((w >> 12) % 256) * 4096 +
                         ((w >> 20) % 2) * 2048 + ((w >> 21) % 1024) * 2);
            if (v >= 1048576) v -= 2097152;
        end
        b.imm     = 64'(v);
        b.illegal = (w % 4 != 3) || !legal || (op == 24 && (f3 == 2 || f3 == 3));
        return b;
    endfunction

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advances one clock edge and applies the same edge to the reference model.
    task automatic tick();
        bit acc, con;
        acc = in_valid && !rst && !flush && (q.size() < 2);
        con = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(decode_model(in_pc, in_inst));
        end
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] inst;
        inst = $urandom;
        if ($urandom_range(3) != 0) inst[1:0] = 2'b11;
        if ($urandom_range(1) != 0) inst[6:2] = 5'(legal_ops[$urandom_range(20)]);
        return inst;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (dut_b !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", dut_b); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_decode();
        logic [31:0] t_inst[6]  = '{32'h00500093, 32'hFE000EE3, 32'h123452B7,
                                    32'h00000000, 32'h0000007F, 32'h00002063};
        logic [63:0] t_imm[6]   = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_1234_5000,
                                    64'd0, 64'd0, 64'd0};
        logic        t_ill[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0]  t_op[6]    = '{5'b00100, 5'b11000, 5'b01101, 5'b00000, 5'b11111, 5'b11000};
        logic [4:0]  t_rd[6]    = '{5'd1, 5'd29, 5'd5, 5'd0, 5'd0, 5'd0};
        logic [63:0] pc;
        for (int i = 0; i < 6; i++) begin
            pc = 64'h1000 + 64'(i * 4);
            drive(1'b1, pc, t_inst[i], 1'b1, 1'b0);
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_valid: got %b want 1", i, out_valid); end
            checks++;
            if (out_pc !== pc) begin errors++; $display("FAIL dec%0d_pc: got %h want %h", i, out_pc, pc); end
            checks++;
            if (out_imm !== t_imm[i]) begin errors++; $display("FAIL dec%0d_imm: got %h want %h", i, out_imm, t_imm[i]); end
            checks++;
            if (out_illegal !== t_ill[i]) begin errors++; $display("FAIL dec%0d_illegal: got %b want %b", i, out_illegal, t_ill[i]); end
            checks++;
            if (out_opcode !== t_op[i] || out_rd !== t_rd[i]) begin
                errors++;
                $display("FAIL dec%0d_fields: got op=%b rd=%0d want op=%b rd=%0d", i, out_opcode, out_rd, t_op[i], t_rd[i]);
            end
            checks++;
            if (q.size() == 0 || dut_b !== q[0]) begin errors++; $display("FAIL dec%0d_model: got %h", i, dut_b); end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] pcs[3]    = '{64'h2000, 64'h2004, 64'h2008};
        logic        exp_rdy[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] insts[3];
        bit          c_pending;
        for (int i = 0; i < 3; i++) insts[i] = rand_inst();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, pcs[k < 3 ? k : 2], insts[k < 3 ? k : 2], 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (in_ready !== exp_rdy[k]) begin errors++; $display("FAIL bp_in_ready%0d: got %b want %b", k, in_ready, exp_rdy[k]); end
            tick();
        end
        c_pending = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(c_pending, pcs[2], insts[2], 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[k]) begin
                errors++;
                $display("FAIL bp_order%0d: got valid=%b pc=%h want valid=1 pc=%h", k, out_valid, out_pc, pcs[k]);
            end
            checks++;
            if (q.size() == 0 || dut_b !== q[0]) begin errors++; $display("FAIL bp_model%0d: got %h", k, dut_b); end
            if (c_pending && q.size() < 2) begin
                tick();
                c_pending = 1'b0;
            end else begin
                tick();
            end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 64'h4000, rand_inst(), 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h4004, rand_inst(), 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h4008, rand_inst(), 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: got pc=%h valid=%b want valid=0", k, out_pc, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 64'h5000, rand_inst(), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_one: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        drive(1'b1, 64'h3000, 32'h00500093, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 64'd5 || out_pc !== 64'h3000) begin
            errors++;
            $display("FAIL rmid_decode: got valid=%b imm=%h pc=%h want 1/5/3000", out_valid, out_imm, out_pc);
        end
        checks++;
        if (q.size() == 0 || dut_b !== q[0]) begin errors++; $display("FAIL rmid_model: got %h", dut_b); end
        tick();
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(59) == 0);
            drive($urandom_range(3) != 0, {$urandom, $urandom}, rand_inst(),
                  $urandom_range(2) != 0, $urandom_range(24) == 0);
            @(negedge clk);
            exp_rdy = (q.size() < 2) && !rst;
            checks++;
            if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd%0d_valid: got %b want %b", n, out_valid, q.size() > 0); end
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd%0d_in_ready: got %b want %b", n, in_ready, exp_rdy); end
            if (q.size() > 0) begin
                checks++;
                if (dut_b !== q[0]) begin errors++; $display("FAIL rnd%0d_data: got %h want %h", n, dut_b, q[0]); end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
